// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage RV32 core: per-stage stall vector, flush
// strobes, instruction-fetch and data-memory handshake sequencing, and the
// stall-cycle performance counter.
module pipe_ctrl #(
  parameter int STAGE_NUM = 6,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 imem_ack,
  output logic                 imem_req,
  output logic                 imem_kill,
  input  logic                 id_loaduse,
  input  logic                 ex_branch_taken,
  input  logic                 mem_memrd,
  input  logic                 mem_memwr,
  input  logic                 dmem_done,
  output logic                 dmem_req,
  input  logic                 trap,
  output logic [STAGE_NUM-1:0] stall,
  output logic                 flush,
  output logic                 branch_flush,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int PC_STAGE = 0;
  localparam int ID_STAGE = 2;
  localparam int EX_STAGE = 3;
  localparam int WB_STAGE = 5;

  // Each mask stalls every stage before the one that takes the bubble.
  localparam logic [STAGE_NUM-1:0] DMEM_MASK = STAGE_NUM'((1 << WB_STAGE) - 1);
  localparam logic [STAGE_NUM-1:0] LU_MASK   = STAGE_NUM'((1 << EX_STAGE) - 1);
  localparam logic [STAGE_NUM-1:0] IF_MASK   = STAGE_NUM'((1 << ID_STAGE) - 1);

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_KILL} i_state_e;
  typedef enum logic       {D_IDLE, D_WAIT}         d_state_e;

  i_state_e         i_state_q, i_state_d;
  d_state_e         d_state_q, d_state_d;
  logic             started_q;
  logic             trap_pend_q, trap_pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic dmem_stall;
  logic lu_stall;
  logic if_stall;

  // Handshake requests, hazard resolution and stall/flush outputs.
  always_comb begin
    // NOTE: every signal gets a value on every path through always_comb;
    // a missing branch would infer a latch.
    dmem_req     = (d_state_q == D_WAIT) | mem_memrd | mem_memwr;
    dmem_stall   = dmem_req & ~dmem_done;
    // A taken branch wins: the dependent instruction is on the wrong path.
    lu_stall     = id_loaduse & ~dmem_stall & ~ex_branch_taken;
    // A pending trap waits for the in-flight data access to finish.
    flush        = (trap | trap_pend_q) & ~dmem_stall;
    branch_flush = ex_branch_taken & ~dmem_stall & ~flush;
    // Request logic reads only state and inputs, never stall, so no loop.
    imem_req     = (i_state_q != I_IDLE) | (started_q & ~dmem_stall & ~lu_stall);
    imem_kill    = (i_state_q == I_KILL) & imem_ack;
    if_stall     = (imem_req & ~imem_ack) | (i_state_q == I_KILL);
    stall        = '0;
    if (!flush) begin
      stall = ({STAGE_NUM{dmem_stall}} & DMEM_MASK)
            | ({STAGE_NUM{lu_stall}}   & LU_MASK)
            | ({STAGE_NUM{if_stall}}   & IF_MASK);
    end
  end

  // Next-state for both FSMs, the trap latch and the stall counter.
  always_comb begin
    i_state_d = i_state_q;
    unique case (i_state_q)
      I_IDLE: if (imem_req && !imem_ack) i_state_d = I_WAIT;
      I_WAIT: begin
        if (imem_ack)                   i_state_d = I_IDLE;
        else if (branch_flush || flush) i_state_d = I_KILL;
      end
      I_KILL: if (imem_ack) i_state_d = I_IDLE;
      default: i_state_d = I_IDLE;
    endcase

    d_state_d = d_state_q;
    unique case (d_state_q)
      D_IDLE:  if (dmem_req && !dmem_done) d_state_d = D_WAIT;
      D_WAIT:  if (dmem_done)              d_state_d = D_IDLE;
      default: d_state_d = D_IDLE;
    endcase

    // A second trap while one is pending is absorbed into the same flush.
    trap_pend_d = trap_pend_q;
    if (flush)                  trap_pend_d = 1'b0;
    else if (trap && dmem_stall) trap_pend_d = 1'b1;

    stall_cycles_d = stall_cycles_q;
    if (cnt_clr)               stall_cycles_d = '0;
    else if (stall[PC_STAGE])  stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // State registers; reset returns both FSMs to idle immediately.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      i_state_q      <= I_IDLE;
      d_state_q      <= D_IDLE;
      started_q      <= 1'b0;
      trap_pend_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      i_state_q      <= i_state_d;
      d_state_q      <= d_state_d;
      started_q      <= 1'b1;
      trap_pend_q    <= trap_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the control rules.
// A second instance with a 3-bit counter exercises counter wrap-around.
module tb_pipe_ctrl;

  localparam int SN = 6;
  localparam int NW = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic imem_ack = 1'b0, id_loaduse = 1'b0, ex_branch_taken = 1'b0;
  logic mem_memrd = 1'b0, mem_memwr = 1'b0, dmem_done = 1'b0;
  logic trap = 1'b0, cnt_clr = 1'b0;

  logic          imem_req, imem_kill, dmem_req, flush, branch_flush;
  logic [SN-1:0] stall;
  logic [31:0]   stall_cycles;

  logic          w_imem_req, w_imem_kill, w_dmem_req, w_flush, w_branch_flush;
  logic [SN-1:0] w_stall;
  logic [NW-1:0] w_stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit              m_started, m_fwait, m_fstale, m_dwait, m_tpend;
  longint unsigned m_cnt;

  // Last observed outputs, for scenario-specific checks
  logic [SN-1:0] obs_stall;
  logic          obs_flush, obs_bflush, obs_kill, obs_ireq, obs_dreq;

  pipe_ctrl #(.STAGE_NUM(SN), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_kill(imem_kill),
    .id_loaduse(id_loaduse), .ex_branch_taken(ex_branch_taken),
    .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .dmem_done(dmem_done), .dmem_req(dmem_req),
    .trap(trap), .stall(stall), .flush(flush), .branch_flush(branch_flush),
    .cnt_clr(cnt_clr), .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.STAGE_NUM(SN), .CNT_W(NW)) dut_w (
    .clk(clk), .rstn(rstn),
    .imem_ack(imem_ack), .imem_req(w_imem_req), .imem_kill(w_imem_kill),
    .id_loaduse(id_loaduse), .ex_branch_taken(ex_branch_taken),
    .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .dmem_done(dmem_done), .dmem_req(w_dmem_req),
    .trap(trap), .stall(w_stall), .flush(w_flush), .branch_flush(w_branch_flush),
    .cnt_clr(cnt_clr), .stall_cycles(w_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Hold reset for two cycles with idle inputs; outputs must be at reset values.
  task automatic do_reset();
    rstn = 1'b0;
    {imem_ack, id_loaduse, ex_branch_taken, mem_memrd, mem_memwr, dmem_done, trap, cnt_clr} = '0;
    {m_started, m_fwait, m_fstale, m_dwait, m_tpend} = '0;
    m_cnt = 0;
    #1;
    check("rst_outs", {imem_req, imem_kill, dmem_req, flush, branch_flush, stall}, '0);
    check("rst_cnt", stall_cycles, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_outs_held", {imem_req, imem_kill, dmem_req, flush, branch_flush, stall,
                            w_imem_req, w_dmem_req, w_stall}, '0);
    check("rst_cnt_w", w_stall_cycles, 0);
    rstn = 1'b1;
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic cycle(input bit ack, lu, br, rd, wr, done, trp, clr);
    bit e_dreq, e_dst, e_lu, e_fl, e_bf, e_ireq, e_kill, e_ist;
    int depth;
    logic [SN-1:0] e_stall;
    imem_ack = ack; id_loaduse = lu; ex_branch_taken = br;
    mem_memrd = rd; mem_memwr = wr; dmem_done = done; trap = trp; cnt_clr = clr;
    #1;
    e_dreq = m_dwait || rd || wr;
    e_dst  = e_dreq && !done;
    e_lu   = lu && !e_dst && !br;
    e_fl   = (trp || m_tpend) && !e_dst;
    e_bf   = br && !e_dst && !e_fl;
    e_ireq = m_fwait || m_fstale || (m_started && !e_dst && !e_lu);
    e_kill = m_fstale && ack;
    e_ist  = (e_ireq && !ack) || m_fstale;
    // Number of leading stages held: deepest bubble wins, flush clears all.
    depth  = e_fl ? 0 : e_dst ? 5 : e_lu ? 3 : e_ist ? 2 : 0;
    e_stall = SN'((1 << depth) - 1);

    check("stall", stall, e_stall);
    check("ctl", {imem_req, imem_kill, dmem_req, flush, branch_flush},
                 {e_ireq, e_kill, e_dreq, e_fl, e_bf});
    check("ctl_w", {w_imem_req, w_imem_kill, w_dmem_req, w_flush, w_branch_flush, w_stall},
                   {e_ireq, e_kill, e_dreq, e_fl, e_bf, e_stall});
    obs_stall = stall; obs_flush = flush; obs_bflush = branch_flush;
    obs_kill = imem_kill; obs_ireq = imem_req; obs_dreq = dmem_req;

    @(posedge clk);
    #1;
    // Fetch: an outstanding request finishes on ack; a redirect while
    // waiting marks it stale.
    if (m_fstale)      m_fstale = !ack;
    else if (m_fwait) begin
      if (ack)               m_fwait = 1'b0;
      else if (e_bf || e_fl) begin m_fwait = 1'b0; m_fstale = 1'b1; end
    end else           m_fwait = e_ireq && !ack;
    m_dwait = e_dst;
    if (e_fl)              m_tpend = 1'b0;
    else if (trp && e_dst) m_tpend = 1'b1;
    m_started = 1'b1;
    if (clr)             m_cnt = 0;
    else if (e_stall[0]) m_cnt = m_cnt + 1;
    check("stall_cycles", stall_cycles, m_cnt & 64'hFFFF_FFFF);
    check("stall_cycles_w", w_stall_cycles, m_cnt % (1 << NW));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Zero-wait fetch: request rises one cycle after release, never stalls.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      if (i == 0) check("zw_req_first", obs_ireq, 1'b0);
      if (i == 1) check("zw_req_second", obs_ireq, 1'b1);
    end
    check("zw_cnt", stall_cycles, 0);

    // Fetch wait with branch in the first wait cycle.
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("fw_stall", obs_stall, 6'b000011);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check("fw_bflush", obs_bflush, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("fw_nobflush", obs_bflush, 1'b0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("fw_kill", obs_kill, 1'b1);
    check("fw_kill_stall", obs_stall, 6'b000011);
    check("fw_cnt", stall_cycles, 4);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("fw_refetch", obs_ireq, 1'b1);

    // Load-use, then load-use overridden by a taken branch.
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check("lu_stall", obs_stall, 6'b000111);
    check("lu_cnt", stall_cycles, 1);
    cycle(1, 1, 1, 0, 0, 0, 0, 0);
    check("lu_br_stall", obs_stall, 6'b000000);
    check("lu_br_bflush", obs_bflush, 1'b1);

    // Data wait of four cycles.
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 1, 0, 0, 0, 0);
      check("dw_stall", obs_stall, 6'b011111);
      check("dw_req", obs_dreq, 1'b1);
    end
    cycle(1, 0, 0, 1, 0, 1, 0, 0);
    check("dw_req_done", obs_dreq, 1'b1);
    check("dw_stall_done", obs_stall, 6'b000000);
    check("dw_cnt", stall_cycles, 4);

    // Trap during an outstanding store: flush only when the store completes.
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 1, 0);
    check("tr_noflush0", obs_flush, 1'b0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    check("tr_noflush1", obs_flush, 1'b0);
    cycle(1, 0, 0, 0, 1, 1, 0, 0);
    check("tr_flush", obs_flush, 1'b1);
    check("tr_stall", obs_stall, 6'b000000);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("tr_single", obs_flush, 1'b0);

    // Counter wrap on the narrow instance, and clear during a stall.
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check("wrap_full", w_stall_cycles, 3'd7);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check("wrap_zero", w_stall_cycles, 3'd0);
    check("wrap_wide", stall_cycles, 8);
    cycle(1, 1, 0, 0, 0, 0, 0, 1);
    check("clr_in_stall", stall_cycles, 0);
    check("clr_in_stall_w", w_stall_cycles, 3'd0);

    // Reset while a data access is outstanding; a late done is ignored.
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    check("late_done_req", obs_dreq, 1'b0);
    check("late_done_stall", obs_stall, 6'b000000);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 99) < 20),
            bit'($urandom_range(0, 99) < 15), bit'($urandom_range(0, 99) < 20),
            bit'($urandom_range(0, 99) < 20), bit'($urandom_range(0, 99) < 50),
            bit'($urandom_range(0, 99) < 5),  bit'($urandom_range(0, 99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
